// File: rtl/usb_txn_scheduler.sv
// usb_txn_scheduler: round-robin arbiter and two-phase (address, data) USB
// page transaction sequencer driving a single shared packet engine.
module usb_txn_scheduler #(
    parameter int MAX_RETRY = 8,
    parameter int ADDR_ENDP = 4,
    parameter int DATA_ENDP = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [1:0]   req,
    input  logic [1:0]   req_write,
    input  logic [31:0]  req_page,
    input  logic [127:0] req_wdata,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         done_success,
    output logic [63:0]  done_rdata,
    output logic         busy,
    output logic         pe_start,
    output logic [1:0]   pe_kind,
    output logic [3:0]   pe_endp,
    output logic [63:0]  pe_payload,
    input  logic         pe_done,
    input  logic [1:0]   pe_status,
    input  logic [63:0]  pe_rdata
);
    localparam logic [1:0] K_OUT  = 2'b00;
    localparam logic [1:0] K_IN   = 2'b01;
    localparam logic [1:0] K_SEND = 2'b10;
    localparam logic [1:0] K_RECV = 2'b11;
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE, GRANT, A_TOK, A_DAT, D_TOK, D_DAT, FINISH
    } state_t;

    state_t      state, state_nxt;
    logic        owner;      // requester that owns the current transaction
    logic        prio;       // requester that wins a simultaneous request
    logic        winner;
    logic [3:0]  retry, retry_nxt, retry_inc;
    logic        launch;     // next cycle is the first cycle of a phase state
    logic        fin_ok;
    logic        resp, ack;
    logic        wr_q;
    logic [15:0] page_q;
    logic [63:0] wdata_q;

    // Engine response only counts once the launch pulse has been seen.
    assign resp      = pe_done && !pe_start;
    assign ack       = resp && (pe_status == 2'b00);
    assign retry_inc = (retry == RETRY_MAX) ? retry : retry + 4'd1;
    assign winner    = (req == 2'b11) ? prio : req[1];

    assign gnt  = (state == GRANT)  ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign done = (state == FINISH) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy = (state != IDLE);

    // State register, owner/priority tracking and request capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            prio    <= 1'b0;
            retry   <= 4'd0;
            wr_q    <= 1'b0;
            page_q  <= 16'h0;
            wdata_q <= 64'h0;
        end else begin
            state <= state_nxt;
            retry <= retry_nxt;
            if (state == IDLE && |req)
                owner <= winner;
            if (state == GRANT) begin
                prio    <= ~owner;
                wr_q    <= owner ? req_write[1] : req_write[0];
                page_q  <= owner ? req_page[31:16] : req_page[15:0];
                wdata_q <= owner ? req_wdata[127:64] : req_wdata[63:0];
            end
        end
    end

    // Next-state: phase sequencing, retry accounting and completion status.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        launch    = 1'b0;
        fin_ok    = 1'b0;
        case (state)
            IDLE:   if (|req) state_nxt = GRANT;
            GRANT: begin
                state_nxt = A_TOK;
                launch    = 1'b1;
                retry_nxt = 4'd0;
            end
            A_TOK, A_DAT, D_TOK, D_DAT: begin
                if (ack) begin
                    case (state)
                        A_TOK:   state_nxt = A_DAT;
                        A_DAT:   state_nxt = D_TOK;
                        D_TOK:   state_nxt = D_DAT;
                        default: state_nxt = FINISH;
                    endcase
                    launch = (state != D_DAT);
                    fin_ok = (state == D_DAT);
                    if (state == A_DAT) retry_nxt = 4'd0;
                end else if (resp) begin
                    retry_nxt = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_nxt = FINISH;
                    end else begin
                        launch    = 1'b1;
                        state_nxt = (state == A_TOK || state == A_DAT) ? A_TOK : D_TOK;
                    end
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Engine command registers: loaded on each phase launch, held until the next.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pe_start   <= 1'b0;
            pe_kind    <= K_OUT;
            pe_endp    <= 4'h0;
            pe_payload <= 64'h0;
        end else begin
            pe_start <= launch;
            if (launch) begin
                case (state_nxt)
                    A_TOK: begin
                        pe_kind    <= K_OUT;
                        pe_endp    <= 4'(ADDR_ENDP);
                        pe_payload <= 64'h0;
                    end
                    A_DAT: begin
                        pe_kind    <= K_SEND;
                        pe_payload <= {48'h0, page_q};
                    end
                    D_TOK: begin
                        pe_kind    <= wr_q ? K_OUT : K_IN;
                        pe_endp    <= 4'(DATA_ENDP);
                        pe_payload <= 64'h0;
                    end
                    D_DAT: begin
                        pe_kind    <= wr_q ? K_SEND : K_RECV;
                        pe_payload <= wr_q ? wdata_q : 64'h0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Completion status, latched on entry to FINISH and held until the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_success <= 1'b0;
            done_rdata   <= 64'h0;
        end else if (state_nxt == FINISH && state != FINISH) begin
            done_success <= fin_ok;
            done_rdata   <= (fin_ok && !wr_q) ? pe_rdata : 64'h0;
        end
    end

endmodule

// File: doc/usb_txn_scheduler.md
# usb_txn_scheduler

Sequences host-side USB page transactions and shares a single packet engine between two requesters. Each accepted request runs as a two-phase transaction: an address phase (OUT token, DATA0 carrying the page) followed by a data phase (IN + receive DATA0 for reads, OUT + send DATA0 for writes). The block sits between the host's read/write tasks and the bus-level packet engine. It arbitrates round-robin, retries failed phases, and returns status and read data to the requester.

## Interface
- MAX_RETRY, 8: attempts per phase before the transaction fails (1..15).
- ADDR_ENDP, 4: endpoint used for the address phase.
- DATA_ENDP, 8: endpoint used for the data phase.

- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  2  per-requester request level; held until granted.
- req_write  in  2  1 = write, 0 = read, per requester.
- req_page  in  32  {page1, page0}, 16 bits each.
- req_wdata  in  128  {wdata1, wdata0}, 64 bits each.
- gnt  out  2  one-hot, one-cycle pulse; request fields captured this cycle.
- done  out  2  one-hot, one-cycle completion pulse to the owning requester.
- done_success  out  1  valid with done.
- done_rdata  out  64  read data, valid with done; 0 unless successful read.
- busy  out  1  high from gnt through done, inclusive.
- pe_start  out  1  one-cycle pulse launching a packet-engine operation.
- pe_kind  out  2  00 OUT token, 01 IN token, 10 send DATA0, 11 receive DATA0.
- pe_endp  out  4  endpoint for token operations.
- pe_payload  out  64  DATA0 payload for send.
- pe_done  in  1  one-cycle pulse: operation complete.
- pe_status  in  2  with pe_done: 00 ACK/OK, 01 NAK, 10 CRC/PID error, 11 timeout.
- pe_rdata  in  64  received payload, valid with pe_done on receive.

## Operation
- States: IDLE, GRANT, A_TOK, A_DAT, D_TOK, D_DAT, FINISH.
- IDLE: if any req bit set, go to GRANT. The winner is round-robin: the requester not granted last wins a tie. After reset, requester 0 wins ties.
- GRANT: pulse gnt[winner]. Capture write, page, wdata. Clear the retry counter. Go to A_TOK.
- A_TOK: pe_kind=00, pe_endp=ADDR_ENDP. On pe_done with OK, go to A_DAT; with any other status, treat as a phase failure.
- A_DAT: pe_kind=10, pe_payload={48'h0, page}. ACK advances to D_TOK and clears the retry counter. Non-ACK is a phase failure.
- D_TOK: pe_kind=01 for a read, 00 for a write; pe_endp=DATA_ENDP. OK advances to D_DAT; otherwise phase failure.
- D_DAT: pe_kind=11 for a read, 10 with pe_payload=wdata for a write. ACK goes to FINISH with success=1. For a read, pe_rdata is captured.
- Phase failure:
  - Increment the retry counter.
  - If the counter equals MAX_RETRY, go to FINISH with success=0.
  - Otherwise re-enter the token state of the current phase (A_TOK or D_TOK).
- FINISH: pulse done[owner]. Drive done_success and done_rdata. Go to IDLE.
- pe_done outside a waiting phase state is ignored.
- req changes after gnt are ignored until the next IDLE.

## Timing
- Reset (asynchronous): state IDLE. All outputs are 0, including gnt, done, done_success, done_rdata, busy, pe_start, pe_kind, pe_endp and pe_payload. Round-robin pointer is cleared so requester 0 wins ties.
- req seen in IDLE at cycle T gives gnt at T+1.
- pe_start pulses for exactly one cycle on the first cycle of each phase state, including every re-entry on retry.
- pe_kind, pe_endp and pe_payload are registered and stable from pe_start until pe_done.
- pe_done is accepted no earlier than the cycle after pe_start.
- pe_done at cycle N gives pe_start of the next phase at N+1.
- Best-case transaction: gnt to done = 5 + the four engine latencies.
- Done pulses the cycle after the final pe_done. IDLE follows, so the earliest next gnt is 2 cycles after done.
- done_success and done_rdata hold their values until the next done.
- Retry counter is 4 bits. It saturates at MAX_RETRY and never wraps.
- A reset asserted mid-transaction aborts it with no done pulse.

## Test plan
- Read, all ACK. req[0], page 16'h0042, engine returns 64'hDEAD_BEEF_0123_4567. Expect:
  - operations in order: OUT tok ep4, send {48'h0,16'h0042}, IN tok ep8, receive;
  - done[0] with success=1 and rdata=64'hDEAD_BEEF_0123_4567.
- Write, all ACK. req[1], page 16'h1234, wdata 64'hA5A5_5A5A_0F0F_F0F0. Expect the D_DAT payload to equal wdata; done[1] with success=1 and rdata=0.
- Retry. Address DATA0 NAKs twice, then ACKs. Expect:
  - A_TOK+A_DAT issued 3 times;
  - the data phase runs once;
  - success=1.
- Exhaustion. D_DAT returns timeout on every attempt. Expect exactly MAX_RETRY=8 D_TOK/D_DAT attempts, then done with success=0 and rdata=0.
- Arbitration. Both req held continuously. Expect gnt order 0,1,0,1, with no second gnt before the previous done.
- Reset mid-operation. Assert reset_n=0 during D_TOK. Expect all outputs 0 immediately with no done pulse; after release, req[1] alone is granted.
